// File: rtl/axi_r_buffer.sv
// Elastic circular-FIFO buffer for the AXI read-data (R) channel.
// Optional same-cycle bypass when empty: define AXI_R_BUFFER_FALLTHROUGH_EN.
module axi_r_buffer #(
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned USER_WIDTH   = 6,
    parameter int unsigned BUFFER_DEPTH = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              master_valid_i,
    input  logic [DATA_WIDTH-1:0]             master_data_i,
    input  logic [1:0]                        master_resp_i,
    input  logic                              master_last_i,
    input  logic [ID_WIDTH-1:0]               master_id_i,
    input  logic [USER_WIDTH-1:0]             master_user_i,
    output logic                              master_ready_o,
    output logic                              slave_valid_o,
    output logic [DATA_WIDTH-1:0]             slave_data_o,
    output logic [1:0]                        slave_resp_o,
    output logic                              slave_last_o,
    output logic [ID_WIDTH-1:0]               slave_id_o,
    output logic [USER_WIDTH-1:0]             slave_user_o,
    input  logic                              slave_ready_i,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0] level_o
);

    localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

    typedef struct packed {
        logic [USER_WIDTH-1:0] user;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
        logic [1:0]            resp;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t           mem [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    entry_t in_beat;
    entry_t head;
    entry_t out_beat;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    logic   bypass;
    logic   wr_en;
    logic   rd_en;

    assign in_beat = '{user: master_user_i, id: master_id_i, last: master_last_i,
                       resp: master_resp_i, data: master_data_i};
    assign head    = mem[rd_ptr];

    assign full  = (count == CNT_W'(BUFFER_DEPTH));
    assign empty = (count == '0);

    // Ready depends only on stored state and reset, never on slave_ready_i.
    assign master_ready_o = ~full & ~rst_i;
    assign push           = master_valid_i & master_ready_o;

`ifdef AXI_R_BUFFER_FALLTHROUGH_EN
    // When empty, present the incoming beat directly; it skips storage if taken now.
    assign slave_valid_o = empty ? push : 1'b1;
    assign out_beat      = empty ? in_beat : head;
    assign bypass        = empty & push & slave_ready_i;
`else
    assign slave_valid_o = ~empty;
    assign out_beat      = head;
    assign bypass        = 1'b0;
`endif

    assign pop   = slave_valid_o & slave_ready_i;
    assign wr_en = push & ~bypass;
    assign rd_en = pop & ~bypass;

    assign slave_data_o = out_beat.data;
    assign slave_resp_o = out_beat.resp;
    assign slave_last_o = out_beat.last;
    assign slave_id_o   = out_beat.id;
    assign slave_user_o = out_beat.user;
    assign level_o      = count;

    // Pointers wrap by explicit compare so any depth >= 2 works.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < BUFFER_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= in_beat;
                wr_ptr      <= (wr_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_r_buffer.sv
// Bench for axi_r_buffer: depth-2 and depth-3 instances share stimulus and
// are checked every cycle against a queue model, plus directed literal checks.
module tb_axi_r_buffer;

    typedef struct packed {
        logic [5:0]  user;
        logic [3:0]  id;
        logic        last;
        logic [1:0]  resp;
        logic [63:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mv;
    logic [63:0] din;
    logic [1:0]  rin;
    logic        lin;
    logic [3:0]  iin;
    logic [5:0]  uin;
    logic        sr;

    logic        mr   [2];
    logic        sv   [2];
    logic [63:0] sd   [2];
    logic [1:0]  sresp[2];
    logic        slast[2];
    logic [3:0]  sid  [2];
    logic [5:0]  suser[2];
    logic [1:0]  lvl  [2];

    int npass = 0;
    int ntot  = 0;
    bit check_en = 1'b0;

    beat_t mq [2][$];
    bit    fresh  [2] = '{1'b1, 1'b1};
    int    popped [2] = '{0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_r_buffer #(
            .ID_WIDTH(4), .DATA_WIDTH(64), .USER_WIDTH(6),
            .BUFFER_DEPTH((g == 0) ? 2 : 3)
        ) dut (
            .clk_i(clk), .rst_i(rst),
            .master_valid_i(mv), .master_data_i(din), .master_resp_i(rin),
            .master_last_i(lin), .master_id_i(iin), .master_user_i(uin),
            .master_ready_o(mr[g]),
            .slave_valid_o(sv[g]), .slave_data_o(sd[g]), .slave_resp_o(sresp[g]),
            .slave_last_o(slast[g]), .slave_id_o(sid[g]), .slave_user_o(suser[g]),
            .slave_ready_i(sr), .level_o(lvl[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s inst%0d: got 0x%0h, want 0x%0h", name, g, act, exp);
    endtask

    // Queue model: compare on the falling edge, then advance as of the next rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            for (int g = 0; g < 2; g++) begin
                int    depth;
                bit    ev;
                bit    er;
                beat_t hb;
                beat_t nb;
                depth = (g == 0) ? 2 : 3;
                ev = (mq[g].size() != 0);
                er = (mq[g].size() != depth) && !rst;
                chk("m_valid", g, 64'(sv[g]), 64'(ev));
                chk("m_ready", g, 64'(mr[g]), 64'(er));
                chk("m_level", g, 64'(lvl[g]), 64'(mq[g].size()));
                if (ev || fresh[g]) begin
                    hb = ev ? mq[g][0] : '0;
                    chk("m_data", g, sd[g], hb.data);
                    chk("m_resp", g, 64'(sresp[g]), 64'(hb.resp));
                    chk("m_last", g, 64'(slast[g]), 64'(hb.last));
                    chk("m_id",   g, 64'(sid[g]), 64'(hb.id));
                    chk("m_user", g, 64'(suser[g]), 64'(hb.user));
                end
                if (rst) begin
                    mq[g].delete();
                    fresh[g] = 1'b1;
                end else begin
                    nb = '{user: uin, id: iin, last: lin, resp: rin, data: din};
                    if (ev && sr) begin
                        void'(mq[g].pop_front());
                        popped[g]++;
                    end
                    if (mv && er) begin
                        mq[g].push_back(nb);
                        fresh[g] = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input logic [63:0] d, input logic [3:0] id, input logic last, input logic [1:0] resp);
        mv = 1'b1; din = d; iin = id; lin = last; rin = resp; uin = 6'(d);
    endtask

    initial begin
        int k;
        int cyc;
        int start;
        bit rd;
        rst = 1'b1; mv = 1'b0; din = '0; rin = '0; lin = 1'b0; iin = '0; uin = '0; sr = 1'b0;
        step();
        check_en = 1'b1;
        chk("rst_valid", 0, 64'(sv[0]), 64'd0);
        chk("rst_level", 0, 64'(lvl[0]), 64'd0);
        chk("rst_ready", 0, 64'(mr[0]), 64'd0);
        chk("rst_data",  0, sd[0], 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("ready_after_rst", 0, 64'(mr[0]), 64'd1);

        // single beat, one-cycle latency
        beat(64'h11, 4'd3, 1'b1, 2'd0); sr = 1'b1;
        #1 chk("lat_not_yet", 0, 64'(sv[0]), 64'd0);
        step();
        mv = 1'b0;
        chk("t1_valid", 0, 64'(sv[0]), 64'd1);
        chk("t1_data",  0, sd[0], 64'h11);
        chk("t1_id",    0, 64'(sid[0]), 64'd3);
        chk("t1_last",  0, 64'(slast[0]), 64'd1);
        chk("t1_level", 0, 64'(lvl[0]), 64'd1);
        step();
        chk("t1_drain", 0, 64'(lvl[0]), 64'd0);

        // fill depth-2 instance, hold a third beat, then release
        sr = 1'b0;
        beat(64'hA0, 4'd1, 1'b0, 2'd0); step();
        beat(64'hA1, 4'd1, 1'b0, 2'd0); step();
        chk("full_level", 0, 64'(lvl[0]), 64'd2);
        chk("full_ready", 0, 64'(mr[0]), 64'd0);
        beat(64'hA2, 4'd1, 1'b1, 2'd0); step();
        chk("held_level", 0, 64'(lvl[0]), 64'd2);
        chk("held_head",  0, sd[0], 64'hA0);
        sr = 1'b1; step();
        chk("pop1_data",  0, sd[0], 64'hA1);
        chk("pop1_ready", 0, 64'(mr[0]), 64'd1);
        step();
        mv = 1'b0;
        chk("pop2_data",  0, sd[0], 64'hA2);
        step();
        chk("t2_empty", 0, 64'(lvl[0]), 64'd0);
        repeat (4) step();

        // back-to-back stream through the depth-3 instance (pointer wrap)
        sr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(64'(i), 4'd2, 1'b0, 2'd0); step();
        end
        chk("b2b_fill", 1, 64'(lvl[1]), 64'd3);
        sr = 1'b1; k = 3;
        for (int e = 0; e < 10; e++) begin
            chk("b2b_valid", 1, 64'(sv[1]), 64'd1);
            chk("b2b_data",  1, sd[1], 64'(e));
            if (k < 10) beat(64'(k), 4'd2, 1'b0, 2'd0);
            else mv = 1'b0;
            rd = mr[1];
            step();
            if (rd && k < 10) k++;
        end
        mv = 1'b0;
        chk("b2b_done", 1, 64'(lvl[1]), 64'd0);
        repeat (3) step();

        // reset with two stored beats
        sr = 1'b0;
        beat(64'hB0, 4'd5, 1'b0, 2'd1); step();
        beat(64'hB1, 4'd5, 1'b1, 2'd1); step();
        mv = 1'b0;
        chk("pre_rst_level", 0, 64'(lvl[0]), 64'd2);
        rst = 1'b1; step();
        rst = 1'b0;
        chk("mid_rst_valid", 0, 64'(sv[0]), 64'd0);
        chk("mid_rst_level", 0, 64'(lvl[0]), 64'd0);
        chk("mid_rst_data",  0, sd[0], 64'd0);
        chk("mid_rst_id",    0, 64'(sid[0]), 64'd0);
        sr = 1'b1;
        beat(64'hC5, 4'd6, 1'b1, 2'd0); step();
        mv = 1'b0;
        chk("post_rst_data", 0, sd[0], 64'hC5);
        step();

        // burst with RLAST on beat 3 and SLVERR on beat 1
        for (int i = 0; i < 4; i++) begin
            beat(64'(16'hD0 + i), 4'd7, (i == 3), (i == 1) ? 2'b10 : 2'b00);
            step();
            chk("burst_data", 0, sd[0], 64'(16'hD0 + i));
            chk("burst_last", 0, 64'(slast[0]), 64'(i == 3));
            chk("burst_resp", 0, 64'(sresp[0]), (i == 1) ? 64'd2 : 64'd0);
        end
        mv = 1'b0;
        repeat (3) step();

        // random valid/ready, model checks order, stability and level
        cyc = 0; start = popped[0];
        while ((popped[0] - start) < 2000 && cyc < 20000) begin
            mv  = 1'($urandom_range(0, 1));
            sr  = 1'($urandom_range(0, 1));
            din = {$urandom, $urandom};
            rin = 2'($urandom);
            lin = 1'($urandom);
            iin = 4'($urandom);
            uin = 6'($urandom);
            step();
            cyc++;
        end
        chk("rand_beats", 0, 64'((popped[0] - start) >= 2000), 64'd1);
        mv = 1'b0; sr = 1'b1;
        repeat (4) step();
        chk("final_empty", 1, 64'(lvl[1]), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
